// File: rtl/ttrng_conditioner.sv
// ----------------------------------------------------------------------------
// ttrng_conditioner
//
// Purpose:
//   Conditions a raw ring-oscillator entropy bit into bytes for the ttrng
//   number input. The raw bit is synchronised, sampled on enabled cycles,
//   passed through one of four conditioning modes, and packed eight bits at
//   a time into a single-entry valid/ready output slot. A repetition-count
//   health test latches a sticky failure flag that stops byte production.
//
// Parameters:
//   REP_LIMIT   - run length of identical samples that trips the health
//                 test (2..255)
//
// Ports:
//   clk         - in   single clock, rising edge
//   rst_n       - in   asynchronous active-low reset
//   ena         - in   sampling enable; 0 freezes everything but the handshake
//   raw_bit     - in   asynchronous entropy bit
//   selector    - in   [1:0] mode: 00 raw, 01 von Neumann, 10 XOR-pair,
//                      11 LFSR test pattern
//   number      - out  [7:0] assembled byte, oldest bit in number[7]
//   valid       - out  number holds an untaken byte
//   ready       - in   consumer takes the byte on an edge with valid & ready
//   health_fail - out  sticky repetition-count failure
// ----------------------------------------------------------------------------
module ttrng_conditioner #(
    parameter int unsigned REP_LIMIT = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       raw_bit,
    input  logic [1:0] selector,
    output logic [7:0] number,
    output logic       valid,
    input  logic       ready,
    output logic       health_fail
);

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } pair_state_e;

    localparam logic [1:0] MODE_RAW  = 2'b00;
    localparam logic [1:0] MODE_VN   = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_LFSR = 2'b11;

    localparam logic [3:0] COUNT_FULL = 4'd8;
    localparam logic [7:0] LFSR_SEED  = 8'h01;
    localparam logic [7:0] RUN_LIMIT  = 8'(REP_LIMIT);

    // Synchroniser (free-running; ena only gates the fill counter).
    logic        sync1_q, sync2_q;

    // Sampling and conditioning state.
    logic [1:0]  fill_q,   fill_d;
    pair_state_e state_q,  state_d;
    logic        a_q,      a_d;
    logic [1:0]  sel_q,    sel_d;
    logic [7:0]  lfsr_q,   lfsr_d;

    // Byte assembly.
    logic [7:0]  shift_q,  shift_d;
    logic [3:0]  count_q,  count_d;

    // Health test.
    logic [7:0]  run_q,    run_d;
    logic        prev_q,   prev_d;
    logic        fail_q,   fail_d;

    // Output slot.
    logic [7:0]  number_q, number_d;
    logic        valid_q,  valid_d;

    // Combinational helpers.
    logic        sample;
    logic        sample_en;
    logic        sel_chg;
    logic        take;
    logic        slot_free;
    logic        trip;
    logic        fail_now;
    logic        bit_vld;
    logic        bit_val;
    logic [7:0]  shift_next;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous raw bit.
    // ------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the two
    // synchroniser stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_bit;
            sync2_q <= sync1_q;
        end
    end

    assign sample = sync2_q;

    // ------------------------------------------------------------------------
    // Next-state logic for sampling, conditioning, assembly and output slot.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d and helper gets its hold/idle value first so that no
        // path through the branches below leaves a signal unassigned, which
        // would otherwise infer a latch.
        fill_d     = fill_q;
        state_d    = state_q;
        a_d        = a_q;
        sel_d      = sel_q;
        lfsr_d     = lfsr_q;
        shift_d    = shift_q;
        count_d    = count_q;
        run_d      = run_q;
        prev_d     = prev_q;
        fail_d     = fail_q;
        number_d   = number_q;
        valid_d    = valid_q;
        trip       = 1'b0;
        bit_vld    = 1'b0;
        bit_val    = 1'b0;
        shift_next = {shift_q[6:0], 1'b0};

        // Handshake runs regardless of ena.
        take      = valid_q & ready;
        slot_free = ~valid_q | take;
        if (take) begin
            valid_d = 1'b0;
        end

        // The first two enabled cycles only fill the synchroniser.
        sample_en = ena && (fill_q == 2'd2);
        if (ena && (fill_q != 2'd2)) begin
            fill_d = fill_q + 2'd1;
        end

        // Mode changes are acted on at the next enabled edge so that ena=0
        // keeps the FSM and partial byte frozen.
        sel_chg = ena && (selector != sel_q);
        if (ena) begin
            sel_d = selector;
        end

        // Repetition-count health test; the LFSR mode is deterministic and
        // would trip it falsely, so it is excluded.
        if (sample_en && (selector != MODE_LFSR)) begin
            prev_d = sample;
            if ((run_q == 8'd0) || (sample != prev_q)) begin
                run_d = 8'd1;
            end else if (run_q != 8'hFF) begin
                run_d = run_q + 8'd1;
            end
            trip = (run_d == RUN_LIMIT);
        end
        fail_now = fail_q | trip;
        fail_d   = fail_now;

        // Conditioning: produce at most one candidate bit per sample.
        if (sel_chg) begin
            state_d = ST_FIRST;
        end else if (sample_en) begin
            unique case (selector)
                MODE_RAW: begin
                    bit_vld = 1'b1;
                    bit_val = sample;
                end
                MODE_VN, MODE_XOR: begin
                    if (state_q == ST_FIRST) begin
                        a_d     = sample;
                        state_d = ST_SECOND;
                    end else begin
                        state_d = ST_FIRST;
                        if (selector == MODE_VN) begin
                            bit_vld = (a_q != sample);
                            bit_val = a_q;
                        end else begin
                            bit_vld = 1'b1;
                            bit_val = a_q ^ sample;
                        end
                    end
                end
                MODE_LFSR: begin
                    bit_vld = 1'b1;
                    bit_val = lfsr_q[7];
                end
                default: begin
                    bit_vld = 1'b0;
                end
            endcase
        end

        shift_next = {shift_q[6:0], bit_val};

        // Byte assembly and slot loading.
        if (fail_now) begin
            // A failed source must not emit anything more; whatever is
            // already in the output slot still drains.
            count_d = 4'd0;
        end else if (count_q == COUNT_FULL) begin
            // A full byte is parked in shift_q; further bits are dropped
            // until the slot frees up.
            if (slot_free) begin
                number_d = shift_q;
                valid_d  = 1'b1;
                count_d  = 4'd0;
            end
        end else if (sel_chg) begin
            count_d = 4'd0;
        end else if (bit_vld) begin
            // The LFSR only steps when its bit actually lands in the byte,
            // so the test pattern is never skipped by back-pressure.
            if (selector == MODE_LFSR) begin
                lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            end
            shift_d = shift_next;
            if (count_q == 4'd7) begin
                if (slot_free) begin
                    number_d = shift_next;
                    valid_d  = 1'b1;
                    count_d  = 4'd0;
                end else begin
                    count_d = COUNT_FULL;
                end
            end else begin
                count_d = count_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q   <= 2'd0;
            state_q  <= ST_FIRST;
            a_q      <= 1'b0;
            sel_q    <= MODE_RAW;
            lfsr_q   <= LFSR_SEED;
            shift_q  <= 8'h00;
            count_q  <= 4'd0;
            run_q    <= 8'd0;
            prev_q   <= 1'b0;
            fail_q   <= 1'b0;
            number_q <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            fill_q   <= fill_d;
            state_q  <= state_d;
            a_q      <= a_d;
            sel_q    <= sel_d;
            lfsr_q   <= lfsr_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            run_q    <= run_d;
            prev_q   <= prev_d;
            fail_q   <= fail_d;
            number_q <= number_d;
            valid_q  <= valid_d;
        end
    end

    assign number      = number_q;
    assign valid       = valid_q;
    assign health_fail = fail_q;

endmodule

// File: tb/tb_ttrng_conditioner.sv
// ----------------------------------------------------------------------------
// tb_ttrng_conditioner
//
// Self-checking bench for ttrng_conditioner. A behavioural model built from
// queues (raw-sample delay line, pending pair, partial-byte bit list) tracks
// the expected number/valid/health_fail; a compare process checks the DUT
// against it on every falling edge. Directed scenarios add literal
// expectations, followed by randomized segments.
// ----------------------------------------------------------------------------
module tb_ttrng_conditioner;

    localparam int REP_LIMIT = 31;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       raw_bit;
    logic [1:0] selector;
    logic [7:0] number;
    logic       valid;
    logic       ready;
    logic       health_fail;

    int checks = 0;
    int errors = 0;

    ttrng_conditioner #(.REP_LIMIT(REP_LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .raw_bit    (raw_bit),
        .selector   (selector),
        .number     (number),
        .valid      (valid),
        .ready      (ready),
        .health_fail(health_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    logic [7:0] m_number;
    bit         m_valid;
    bit         m_fail;
    bit         m_delay[$];   // raw values seen at the last two edges
    bit         m_pair[$];    // first sample of an open pair
    bit         m_part[$];    // accepted bits of the byte being built
    bit         m_have_pend;
    logic [7:0] m_pend;
    logic [7:0] m_lfsr;
    int         m_run;
    bit         m_prev;
    logic [1:0] m_sel;
    int         m_fill;

    task automatic m_reset();
        m_number    = 8'h00;
        m_valid     = 1'b0;
        m_fail      = 1'b0;
        m_delay     = '{1'b0, 1'b0};
        m_pair      = {};
        m_part      = {};
        m_have_pend = 1'b0;
        m_pend      = 8'h00;
        m_lfsr      = 8'h01;
        m_run       = 0;
        m_prev      = 1'b0;
        m_sel       = 2'b00;
        m_fill      = 0;
    endtask

    function automatic logic [7:0] pack_bits(input bit bits[$]);
        logic [7:0] b = 8'h00;
        foreach (bits[i]) b = {b[6:0], bits[i]};
        return b;
    endfunction

    task automatic m_step();
        bit s, take, free, sampling, chg, trip, fail_now, bv, bval, a;
        logic [7:0] byte_v;
        // Sample seen this edge is the raw value from two edges ago.
        s = m_delay.pop_front();
        m_delay.push_back(raw_bit);

        take = m_valid && ready;
        free = !m_valid || take;
        if (take) m_valid = 1'b0;

        sampling = ena && (m_fill >= 2);
        if (ena && m_fill < 2) m_fill++;

        chg = ena && (selector != m_sel);
        if (ena) m_sel = selector;

        trip = 1'b0;
        if (sampling && selector != 2'b11) begin
            if (m_run == 0 || s != m_prev) m_run = 1;
            else m_run++;
            m_prev = s;
            trip = (m_run == REP_LIMIT);
        end
        fail_now = m_fail || trip;
        m_fail   = fail_now;

        bv = 1'b0;
        bval = 1'b0;
        if (chg) begin
            m_pair = {};
        end else if (sampling) begin
            case (selector)
                2'b00: begin bv = 1'b1; bval = s; end
                2'b01, 2'b10: begin
                    if (m_pair.size() == 0) begin
                        m_pair.push_back(s);
                    end else begin
                        a = m_pair.pop_front();
                        if (selector == 2'b01) begin
                            bv = (a != s);
                            bval = a;
                        end else begin
                            bv = 1'b1;
                            bval = a ^ s;
                        end
                    end
                end
                default: begin bv = 1'b1; bval = m_lfsr[7]; end
            endcase
        end

        if (fail_now) begin
            m_part = {};
            m_have_pend = 1'b0;
        end else if (m_have_pend) begin
            if (free) begin
                m_number = m_pend;
                m_valid = 1'b1;
                m_have_pend = 1'b0;
            end
        end else if (chg) begin
            m_part = {};
        end else if (bv) begin
            if (selector == 2'b11)
                m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            m_part.push_back(bval);
            if (m_part.size() == 8) begin
                byte_v = pack_bits(m_part);
                m_part = {};
                if (free) begin
                    m_number = byte_v;
                    m_valid = 1'b1;
                end else begin
                    m_pend = byte_v;
                    m_have_pend = 1'b1;
                end
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // Compare process: outputs are registered, so the falling edge is a
    // stable point to sample them.
    initial begin
        forever begin
            @(negedge clk);
            check("model_number", 32'(number), 32'(m_number));
            check("model_valid", 32'(valid), 32'(m_valid));
            check("model_health_fail", 32'(health_fail), 32'(m_fail));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start(input logic [1:0] sel, input logic rdy);
        @(negedge clk);
        rst_n    = 1'b0;
        ena      = 1'b1;
        selector = sel;
        ready    = rdy;
        raw_bit  = 1'b0;
        tick();
        check("reset_number", 32'(number), 32'h00);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_health_fail", 32'(health_fail), 32'h0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] qd;
        logic [19:0] vn;
        int bytes, first_edge;
        logic [7:0] first_num;
        int bias;
        bit prev_raw;

        rst_n = 1'b0;
        ena = 1'b0;
        raw_bit = 1'b0;
        selector = 2'b00;
        ready = 1'b0;

        // Raw mode, fixed pattern: byte lands on the 10th edge.
        pat = 8'hB2;
        start(2'b00, 1'b1);
        for (int k = 0; k < 10; k++) begin
            raw_bit = (k < 8) ? pat[7-k] : 1'b0;
            tick();
            if (k == 8) check("raw_not_early", 32'(valid), 32'h0);
        end
        check("raw_byte_number", 32'(number), 32'hB2);
        check("raw_byte_valid", 32'(valid), 32'h1);

        // Von Neumann: (0,1),(1,0),(1,1),(0,0) repeated yields only 0x55.
        qd = 8'b0110_1100;
        bytes = 0;
        start(2'b01, 1'b1);
        for (int k = 1; k <= 66; k++) begin
            raw_bit = qd[7 - ((k - 1) % 8)];
            tick();
            if (valid) begin
                bytes++;
                check("vn_byte", 32'(number), 32'h55);
            end
        end
        check("vn_byte_count", 32'(bytes), 32'd2);

        // LFSR with back-pressure: 0x01 held, 0x1C pending, one ready pulse.
        start(2'b11, 1'b0);
        for (int k = 0; k < 20; k++) tick();
        check("lfsr_hold_number", 32'(number), 32'h01);
        check("lfsr_hold_valid", 32'(valid), 32'h1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("lfsr_second_number", 32'(number), 32'h1C);
        check("lfsr_second_valid", 32'(valid), 32'h1);
        tick();
        tick();

        // Reset mid-handshake clears the slot at once; LFSR restarts.
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_number", 32'(number), 32'h00);
        check("async_reset_valid", 32'(valid), 32'h0);
        start(2'b11, 1'b0);
        for (int k = 0; k < 12; k++) tick();
        check("lfsr_restart_number", 32'(number), 32'h01);

        // Stuck-at-0: three zero bytes, health_fail on edge 33, then silence.
        bytes = 0;
        start(2'b00, 1'b1);
        raw_bit = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            tick();
            if (valid) begin
                bytes++;
                check("stuck_byte", 32'(number), 32'h00);
            end
            if (e == 32) check("stuck_hf_edge32", 32'(health_fail), 32'h0);
            if (e == 33) check("stuck_hf_edge33", 32'(health_fail), 32'h1);
        end
        check("stuck_byte_count", 32'(bytes), 32'd3);
        check("stuck_hf_sticky", 32'(health_fail), 32'h1);

        // Mode switch 00->01 after 5 raw bits: partial byte dropped, next
        // byte built from VN pairs giving bits 0,1,1,0,0,0,1,1 = 0x63.
        vn = 20'b01_10_11_10_01_00_01_01_10_10;
        first_edge = 0;
        first_num = 8'h00;
        start(2'b00, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            raw_bit = (k <= 6) ? 1'($urandom_range(0, 1)) :
                      (k <= 26) ? vn[19 - (k - 7)] : 1'b0;
            selector = (k >= 8) ? 2'b01 : 2'b00;
            tick();
            if (valid && first_edge == 0) begin
                first_edge = k;
                first_num = number;
            end
        end
        check("switch_first_edge", 32'(first_edge), 32'd28);
        check("switch_first_byte", 32'(first_num), 32'h63);

        // Randomized segments; the compare process does the checking.
        for (int seg = 0; seg < 8; seg++) begin
            bias = (seg == 6) ? 97 : 50;
            start(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            prev_raw = 1'b0;
            for (int c = 0; c < 500; c++) begin
                ena = ($urandom_range(0, 99) < 85);
                ready = ($urandom_range(0, 99) < ((seg % 2 == 0) ? 30 : 70));
                if ($urandom_range(0, 99) < 2) selector = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 99) >= bias) prev_raw = ~prev_raw;
                else if (bias == 50) prev_raw = 1'($urandom_range(0, 1));
                raw_bit = prev_raw;
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
